mem_initializer: RTL and testbench

MEM_INITIALIZER -- requirements
Module: mem_initializer

---
 rtl/mem_initializer.sv | 177 +++++++++++++++++
 tb/tb_mem_initializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initializer.sv
// Memory initializer: writes a pattern over DEPTH words, optionally reads it back and checks it.
module mem_initializer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] s_q,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_data,
  output logic              s_wren,
  output logic              busy,
  output logic              finish,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RD_LAT - 1);

  function automatic logic [DATA_W-1:0] expected(input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] f,
                                                 input logic [ADDR_W-1:0] a);
    case (m)
      2'b01:   expected = f;
      2'b10:   expected = DATA_W'(32'(DEPTH - 1) - 32'(a));
      default: expected = DATA_W'(a);
    endcase
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wren_q;
  logic              busy_q;
  logic              fin_q;
  logic              err_q;
  logic [ADDR_W-1:0] ea_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic              issue_q;
  logic [1:0]        drain_q;
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic [RD_LAT-1:0] pv_q;

  logic [ADDR_W-1:0] addr_d;
  logic              push;
  logic              miss;

  always_comb begin
    addr_d = addr_q + 1'b1;
    push   = (state_q == VERIFY) && issue_q && !abort;
    miss   = (state_q == VERIFY) && !abort && pv_q[RD_LAT-1] &&
             (s_q != expected(mode_q, fill_q, pa_q[RD_LAT-1]));
  end

  // Read-address/valid delay line: the oldest entry lines up with s_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
    end else begin
      pa_q[0] <= addr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) pa_q[i] <= pa_q[i-1];
      if (state_q != VERIFY) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= push;
        for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
      end
    end
  end

  // Control FSM with registered memory-side and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      ea_q    <= '0;
      mode_q  <= '0;
      fill_q  <= '0;
      issue_q <= 1'b0;
      drain_q <= '0;
    end else begin
      fin_q <= 1'b0;
      if (miss && !err_q) begin
        err_q <= 1'b1;
        ea_q  <= pa_q[RD_LAT-1];
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WRITE;
            mode_q  <= mode;
            fill_q  <= fill_value;
            err_q   <= 1'b0;
            ea_q    <= '0;
            addr_q  <= '0;
            data_q  <= expected(mode, fill_value, '0);
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (addr_q == LAST) begin
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            if (mode_q == 2'b11) begin
              state_q <= VERIFY;
              issue_q <= 1'b1;
              drain_q <= '0;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              fin_q   <= 1'b1;
            end
          end else begin
            addr_q <= addr_d;
            data_q <= expected(mode_q, fill_q, addr_d);
          end
        end
        VERIFY: begin
          if (abort) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            issue_q <= 1'b0;
          end else if (issue_q) begin
            if (addr_q == LAST) begin
              issue_q <= 1'b0;
              addr_q  <= '0;
            end else begin
              addr_q <= addr_d;
            end
          end else if (drain_q == LAST_DRAIN) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            fin_q   <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_address = addr_q;
  assign s_data    = data_q;
  assign s_wren    = wren_q;
  assign busy      = busy_q;
  assign finish    = fin_q;
  assign error     = err_q;
  assign err_addr  = ea_q;

endmodule

// File: tb/tb_mem_initializer.sv
module tb_mem_initializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start_a, start_b, abort_a, abort_b, corrupt;
  logic [1:0] mode;
  logic [7:0] fill;

  logic [7:0] q_a, addr_a, data_a, ea_a;
  logic       wren_a, busy_a, fin_a, err_a;
  logic [7:0] q_b, data_b;
  logic [3:0] addr_b, ea_b;
  logic       wren_b, busy_b, fin_b, err_b;

  mem_initializer #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .mode(mode),
    .fill_value(fill), .s_q(q_a), .s_address(addr_a), .s_data(data_a), .s_wren(wren_a),
    .busy(busy_a), .finish(fin_a), .error(err_a), .err_addr(ea_a));

  mem_initializer #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .mode(mode),
    .fill_value(fill), .s_q(q_b), .s_address(addr_b), .s_data(data_b), .s_wren(wren_b),
    .busy(busy_b), .finish(fin_b), .error(err_b), .err_addr(ea_b));

  // RAM models: a has 2-cycle read latency and optional corruption of words 17 and 40.
  logic [7:0] mem_a [256];
  logic [7:0] rp_a  [2];
  logic [7:0] mem_b [16];
  logic [7:0] rp_b;
  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= data_a;
    rp_a[0] <= mem_a[addr_a] ^ ((corrupt && (addr_a == 8'd17 || addr_a == 8'd40)) ? 8'h5A : 8'h00);
    rp_a[1] <= rp_a[0];
    if (wren_b) mem_b[addr_b] <= data_b;
    rp_b <= mem_b[addr_b];
  end
  assign q_a = rp_a[1];
  assign q_b = rp_b;

  int sel;
  logic [7:0] o_addr, o_data, o_ea;
  logic       o_wren, o_busy, o_fin, o_err;
  always_comb begin
    if (sel == 0) begin
      o_addr = addr_a; o_data = data_a; o_ea = ea_a;
      o_wren = wren_a; o_busy = busy_a; o_fin = fin_a; o_err = err_a;
    end else begin
      o_addr = {4'h0, addr_b}; o_data = data_b; o_ea = {4'h0, ea_b};
      o_wren = wren_b; o_busy = busy_b; o_fin = fin_b; o_err = err_b;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_data(input logic [1:0] m, input logic [7:0] f,
                                          input int a, input int depth);
    case (m)
      2'd1:    exp_data = f;
      2'd2:    exp_data = 8'(depth - 1 - a);
      default: exp_data = 8'(a);
    endcase
  endfunction

  typedef struct {
    int         sel;
    logic [1:0] mode;
    logic [7:0] fill;
    bit         corrupt;
    int         lat;
    int         writes;
    bit         err;
    logic [7:0] ea;
  } vec_t;

  vec_t vt [9];

  task automatic run_vec(input vec_t v, input int idx);
    int wcount, wbad, bbad, fin_cyc, depth;
    depth   = (v.sel == 0) ? 256 : 16;
    sel     = v.sel;
    corrupt = v.corrupt;
    mode    = v.mode;
    fill    = v.fill;
    if (v.sel == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    mode = ~v.mode; fill = ~v.fill;
    check($sformatf("v%0d err_clr", idx), o_err, 0);
    wcount = 0; wbad = 0; bbad = 0; fin_cyc = -1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      if (o_fin) begin
        fin_cyc = cyc;
        break;
      end
      if (!o_busy) bbad++;
      if (o_wren) begin
        if (o_addr != 8'(wcount) || o_data != exp_data(v.mode, v.fill, wcount, depth)) wbad++;
        wcount++;
      end
      tick();
    end
    check($sformatf("v%0d latency", idx), fin_cyc, v.lat);
    check($sformatf("v%0d writes", idx), wcount, v.writes);
    check($sformatf("v%0d bad_writes", idx), wbad, 0);
    check($sformatf("v%0d busy_gaps", idx), bbad, 0);
    check($sformatf("v%0d done_bus", idx), {o_busy, o_wren, o_addr, o_data}, 0);
    check($sformatf("v%0d error", idx), o_err, v.err);
    check($sformatf("v%0d err_addr", idx), o_ea, v.ea);
    tick(); tick(); tick();
    check($sformatf("v%0d fin_pulse", idx), o_fin, 0);
    check($sformatf("v%0d err_hold", idx), {o_err, o_ea}, {v.err, v.ea});
  endtask

  initial begin
    int wcount, wbad, vc, extra;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    corrupt = 1'b0; mode = 2'd0; fill = 8'h00; sel = 0;

    vt[0] = '{0, 2'd0, 8'h00, 1'b0, 257, 256, 1'b0, 8'd0};
    vt[1] = '{0, 2'd1, 8'hA5, 1'b0, 257, 256, 1'b0, 8'd0};
    vt[2] = '{0, 2'd2, 8'h00, 1'b0, 257, 256, 1'b0, 8'd0};
    vt[3] = '{0, 2'd3, 8'h00, 1'b0, 515, 256, 1'b0, 8'd0};
    vt[4] = '{0, 2'd3, 8'h00, 1'b1, 515, 256, 1'b1, 8'd17};
    vt[5] = '{0, 2'd0, 8'h3C, 1'b0, 257, 256, 1'b0, 8'd0};
    vt[6] = '{1, 2'd0, 8'h00, 1'b0, 17,  16,  1'b0, 8'd0};
    vt[7] = '{1, 2'd2, 8'h00, 1'b0, 17,  16,  1'b0, 8'd0};
    vt[8] = '{1, 2'd3, 8'h00, 1'b0, 34,  16,  1'b0, 8'd0};

    tick(); tick(); tick();
    check("reset_a", {addr_a, data_a, wren_a, busy_a, fin_a, err_a, ea_a}, 0);
    check("reset_b", {addr_b, data_b, wren_b, busy_b, fin_b, err_b, ea_b}, 0);

    // First start on the first released edge, start ignored mid-run, abort at address 100.
    reset_n = 1'b1; start_a = 1'b1; mode = 2'd0;
    tick();
    check("first_start", {busy_a, wren_a, addr_a}, {1'b1, 1'b1, 8'd0});
    start_a = 1'b0;
    wcount = 1; wbad = 0;
    for (int c = 0; c < 200 && !(wren_a && addr_a == 8'd100); c++) begin
      start_a = (c >= 10 && c < 20);
      tick();
      if (wren_a) begin
        if (addr_a != 8'(wcount) || data_a != 8'(wcount)) wbad++;
        wcount++;
      end
    end
    start_a = 1'b0;
    check("abort_pre_writes", wcount, 101);
    check("abort_pre_bad", wbad, 0);
    abort_a = 1'b1; start_a = 1'b1;
    tick();
    abort_a = 1'b0; start_a = 1'b0;
    check("abort_idle", {busy_a, wren_a, fin_a, addr_a, data_a}, 0);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wren_a || fin_a || busy_a) extra++;
    end
    check("abort_quiet", extra, 0);

    // Abort mid-VERIFY keeps the captured error.
    corrupt = 1'b1; mode = 2'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vc = 0;
    for (int c = 0; c < 600 && vc < 60; c++) begin
      tick();
      if (busy_a && !wren_a) vc++;
    end
    check("vabort_reach", vc, 60);
    check("vabort_err_mid", {err_a, ea_a}, {1'b1, 8'd17});
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("vabort_idle", {busy_a, wren_a, fin_a}, 0);
    check("vabort_err_kept", {err_a, ea_a}, {1'b1, 8'd17});
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (fin_a || busy_a) extra++;
    end
    check("vabort_quiet", extra, 0);

    // Reset mid-VERIFY clears everything including the sticky error.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vc = 0;
    for (int c = 0; c < 600 && vc < 60; c++) begin
      tick();
      if (busy_a && !wren_a) vc++;
    end
    check("vreset_err_before", err_a, 1);
    reset_n = 1'b0;
    tick();
    check("vreset_outputs", {addr_a, data_a, wren_a, busy_a, fin_a, err_a, ea_a}, 0);
    reset_n = 1'b1;
    corrupt = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
